// File: rtl/t_ff_bank_sequencer.sv
// Toggle-flop bank sequencer.
// A WIDTH-bit bank of toggle flops that accepts one command at a time.
// Single-cycle commands (NOP/SET/CLEAR/TOGGLE) modify the bank directly.
// COUNT_UP/COUNT_DOWN run a multi-cycle count using toggle equations.
// Each step of a count is qualified by enable.
// done, wrap and err are registered one-cycle pulses.
module t_ff_bank_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_CLEAR  = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_UP     = 3'b100;
    localparam logic [2:0] OP_DOWN   = 3'b101;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1 = '1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] remaining, remaining_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             dir_up, dir_up_nxt;
    logic             done_nxt, wrap_nxt, err_nxt;

    // One count step built from toggle equations.
    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    // Bit 0 always toggles.
    function automatic logic [WIDTH-1:0] toggle_step(input logic [WIDTH-1:0] cur,
                                                     input logic up);
        logic [WIDTH-1:0] t;
        logic             run;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = run;
            run  = run & (up ? cur[i] : ~cur[i]);
        end
        return cur ^ t;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == COUNT);

    // State, bank, step counter and registered pulses; reset clears all of it asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= ZERO;
            q         <= ZERO;
            dir_up    <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            q         <= q_nxt;
            dir_up    <= dir_up_nxt;
            done      <= done_nxt;
            wrap      <= wrap_nxt;
            err       <= err_nxt;
        end
    end

    // Command decode in IDLE and count stepping in COUNT.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        q_nxt         = q;
        dir_up_nxt    = dir_up;
        done_nxt      = 1'b0;
        wrap_nxt      = 1'b0;
        err_nxt       = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP:    done_nxt = 1'b1;
                        OP_SET: begin
                            q_nxt    = q | cmd_data;
                            done_nxt = 1'b1;
                        end
                        OP_CLEAR: begin
                            q_nxt    = q & ~cmd_data;
                            done_nxt = 1'b1;
                        end
                        OP_TOGGLE: begin
                            q_nxt    = q ^ cmd_data;
                            done_nxt = 1'b1;
                        end
                        OP_UP, OP_DOWN: begin
                            // A zero-length count completes immediately, like a NOP.
                            if (cmd_data == ZERO) begin
                                done_nxt = 1'b1;
                            end else begin
                                remaining_nxt = cmd_data;
                                dir_up_nxt    = (cmd_op == OP_UP);
                                state_nxt     = COUNT;
                            end
                        end
                        default: begin
                            err_nxt  = 1'b1;
                            done_nxt = 1'b1;
                        end
                    endcase
                end
            end
            COUNT: begin
                if (enable) begin
                    q_nxt         = toggle_step(q, dir_up);
                    remaining_nxt = remaining - ONE;
                    wrap_nxt      = dir_up ? (q == ALL1) : (q == ZERO);
                    if (remaining == ONE) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_t_ff_bank_sequencer.sv
// Scoreboard bench for t_ff_bank_sequencer.
// The driver applies one stimulus per cycle on the falling edge.
// For each cycle it pushes the expected post-edge state from an arithmetic model.
// The monitor pops one expectation per rising edge and compares it against the DUT.
module tb_t_ff_bank_sequencer;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] q;
    logic         busy, done, wrap, err;

    t_ff_bank_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         ready;
        logic         done;
        logic         wrap;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: bank value, count-in-progress flag, steps left, direction.
    int   m_q    = 0;
    bit   m_busy = 0;
    int   m_rem  = 0;
    bit   m_up   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic check_reset_now();
        check("rst_q", 32'(q), 32'd0);
        check("rst_flags", 32'({busy, cmd_ready, done, wrap, err}), 32'b01000);
    endtask

    // One cycle of stimulus; the model result for the coming rising edge is queued.
    task automatic step(input logic rn, input logic en, input logic v,
                        input logic [2:0] op, input logic [W-1:0] d);
        exp_t e;
        int   old;
        @(negedge clk);
        reset_n   = rn;
        enable    = en;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        e.done = 1'b0;
        e.wrap = 1'b0;
        e.err  = 1'b0;
        if (!rn) begin
            #1;
            check_reset_now();
            m_q    = 0;
            m_busy = 0;
            m_rem  = 0;
        end else if (!m_busy) begin
            if (v) begin
                case (op)
                    3'd0: e.done = 1'b1;
                    3'd1: begin m_q = m_q | int'(d);            e.done = 1'b1; end
                    3'd2: begin m_q = m_q & ~int'(d) & (M - 1); e.done = 1'b1; end
                    3'd3: begin m_q = m_q ^ int'(d);            e.done = 1'b1; end
                    3'd4, 3'd5: begin
                        if (d == 0) e.done = 1'b1;
                        else begin
                            m_busy = 1;
                            m_rem  = int'(d);
                            m_up   = (op == 3'd4);
                        end
                    end
                    default: begin e.done = 1'b1; e.err = 1'b1; end
                endcase
            end
        end else if (en) begin
            old = m_q;
            if (m_up) begin
                m_q    = (m_q + 1) % M;
                e.wrap = (old == M - 1);
            end else begin
                m_q    = (m_q + M - 1) % M;
                e.wrap = (old == 0);
            end
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0;
                e.done = 1'b1;
            end
        end
        e.q     = W'(m_q);
        e.busy  = m_busy;
        e.ready = !m_busy;
        sb.push_back(e);
    endtask

    // Monitor: compare the DUT just after each rising edge with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q", 32'(q), 32'(e.q));
                check("busy_ready_done_wrap_err",
                      32'({busy, cmd_ready, done, wrap, err}),
                      32'({e.busy, e.ready, e.done, e.wrap, e.err}));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       v, en, rn;
        logic [2:0] op;
        logic [W-1:0] d;
        reset_n   = 1'b0;
        enable    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        #1;
        check_reset_now();
        step(0, 0, 0, 3'd0, 8'h00);
        step(0, 0, 0, 3'd0, 8'h00);

        // Single-cycle ops back to back, the first on the edge right after release.
        step(1, 0, 1, 3'd1, 8'hA5);
        step(1, 0, 1, 3'd2, 8'h0F);
        step(1, 0, 1, 3'd3, 8'hFF);
        step(1, 0, 0, 3'd0, 8'h00);

        // Count up through the wrap point.
        step(1, 1, 1, 3'd2, 8'hFF);
        step(1, 1, 1, 3'd1, 8'hFD);
        step(1, 1, 1, 3'd4, 8'd4);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 3'd0, 8'h00);

        // Count down with stalls; commands presented while counting are ignored.
        step(1, 1, 1, 3'd5, 8'd3);
        for (int i = 0; i < 5; i++) step(1, (i % 2) == 0, 1, 3'd1, 8'hFF);
        step(1, 1, 0, 3'd0, 8'h00);
        step(1, 1, 0, 3'd0, 8'h00);

        // Illegal opcodes and zero-length counts.
        step(1, 1, 1, 3'd6, 8'h33);
        step(1, 1, 0, 3'd0, 8'h00);
        step(1, 1, 1, 3'd7, 8'hFF);
        step(1, 1, 1, 3'd4, 8'd0);
        step(1, 1, 1, 3'd5, 8'd0);
        step(1, 1, 0, 3'd0, 8'h00);

        // Long count abandoned by reset; the first edge after release accepts a command.
        step(1, 1, 1, 3'd4, 8'd200);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 3'd0, 8'h00);
        step(0, 1, 0, 3'd0, 8'h00);
        step(0, 1, 0, 3'd0, 8'h00);
        step(1, 1, 1, 3'd1, 8'h01);
        step(1, 1, 0, 3'd0, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 99) != 0);
            en = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 2) != 0);
            op = 3'($urandom_range(0, 7));
            d  = (op == 3'd4 || op == 3'd5) ? W'($urandom_range(0, 6)) : W'($urandom);
            step(rn, en, v, op, d);
        end
        step(1, 1, 0, 3'd0, 8'h00);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
